// File: rtl/tinker_arb_pkg.sv
// Shared types for the tinker memory arbiter: FSM state and access owner encoding.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package tinker_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    ERR_LS  = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  // Memory is 8-byte wide; an LSU access must start on a word boundary.
  function automatic logic word_aligned(input logic [2:0] lo);
    return lo == 3'b000;
  endfunction

endpackage

// File: rtl/tinker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count reflects inc/clr one clock after they are sampled.
// Backpressure: none; holds at MAX while inc stays asserted.
module tinker_sat_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear has priority, increment stops at MAX.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != W'(MAX))) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store; optional grant counters under TINKER_ARB_STATS_EN.
// Latency: grant and mem_req combinational in IDLE; response forwarded in the cycle mem_rvalid arrives (misaligned LSU: 1 cycle).
// Backpressure: one access outstanding; requesters hold req/payload until grant, LSU preferred unless IF has starved MAX_STARVE cycles.
module tinker_mem_arbiter
  import tinker_arb_pkg::*;
#(
  parameter int MAX_STARVE = 4,
  parameter int AW         = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [AW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [AW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [AW-1:0] ls_rdata,
  output logic          ls_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [AW-1:0] mem_rdata
`ifdef TINKER_ARB_STATS_EN
  ,
  output logic [31:0]   if_gnt_cnt,
  output logic [31:0]   ls_gnt_cnt
`endif
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  // Fetches are issued for the whole 8-byte instruction pair.
  localparam logic [AW-1:0] FETCH_MASK = ~AW'(7);

  arb_state_t    state_q, state_d;
  owner_t        win;
  logic [SW-1:0] starve_cnt;
  logic          starve_full;

  assign starve_full = (starve_cnt == SW'(MAX_STARVE));

  tinker_sat_counter #(
    .MAX (MAX_STARVE),
    .W   (SW)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (if_req & ~if_gnt),
    .clr_i   (if_gnt),
    .count_o (starve_cnt)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Arbitration, memory request steering, response return and next state.
  always_comb begin
    state_d   = state_q;
    win       = OWN_NONE;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_gnt    = 1'b0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    ls_err    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        // Grants are combinational, so they are masked while reset is held.
        if (!reset) begin
          if (if_req && (!ls_req || starve_full)) win = OWN_IF;
          else if (ls_req)                        win = OWN_LS;
        end
        case (win)
          OWN_IF: begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = if_addr & FETCH_MASK;
            state_d  = BUSY_IF;
          end
          OWN_LS: begin
            ls_gnt = 1'b1;
            if (word_aligned(ls_addr[2:0])) begin
              mem_req   = 1'b1;
              mem_we    = ls_we;
              mem_addr  = ls_addr;
              mem_wdata = ls_wdata;
              state_d   = BUSY_LS;
            end else begin
              state_d   = ERR_LS;
            end
          end
          default: ;
        endcase
      end
      BUSY_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          state_d   = IDLE;
        end
      end
      BUSY_LS: begin
        if (mem_rvalid) begin
          ls_rvalid = 1'b1;
          ls_rdata  = mem_rdata;
          state_d   = IDLE;
        end
      end
      ERR_LS: begin
        ls_rvalid = 1'b1;
        ls_err    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TINKER_ARB_STATS_EN
  logic [31:0] if_gnt_cnt_q, ls_gnt_cnt_q;

  // Free-running grant counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_gnt_cnt_q <= '0;
      ls_gnt_cnt_q <= '0;
    end else begin
      if (if_gnt) if_gnt_cnt_q <= if_gnt_cnt_q + 32'd1;
      if (ls_gnt) ls_gnt_cnt_q <= ls_gnt_cnt_q + 32'd1;
    end
  end

  assign if_gnt_cnt = if_gnt_cnt_q;
  assign ls_gnt_cnt = ls_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Self-checking bench for tinker_mem_arbiter: directed scenarios then randomized traffic vs a cycle-level reference model.
// Latency: n/a (testbench).
// Backpressure: bench requesters hold req/payload until granted; bench memory answers after 0..3 idle cycles.
`timescale 1ns/1ps
module tb_tinker_mem_arbiter;

  localparam int AW   = 64;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_we, mem_rvalid;
  logic [AW-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we;
  logic [AW-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
`ifdef TINKER_ARB_STATS_EN
  logic [31:0]   if_gnt_cnt, ls_gnt_cnt;
`endif

  always #5 clk = ~clk;

  tinker_mem_arbiter #(.MAX_STARVE(MAXS), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_err     (ls_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef TINKER_ARB_STATS_EN
    ,
    .if_gnt_cnt (if_gnt_cnt),
    .ls_gnt_cnt (ls_gnt_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the memory port (0 none, 1 fetch, 2 LSU, 3 LSU error reply)
  int          m_owner  = 0;
  int          m_starve = 0;
  int unsigned m_if_cnt = 0;
  int unsigned m_ls_cnt = 0;

  // Bench memory
  bit          mem_pend    = 0;
  int          mem_wait    = 0;
  int          lat_fix     = -1;
  bit          stray_en    = 0;
  bit          stray_force = 0;
  bit          rdata_fixed = 0;
  logic [63:0] rdata_fix   = '0;

  // Requester hold flags for random traffic
  bit if_hold = 0;
  bit ls_hold = 0;

  // Observations from the last checked cycle
  logic        obs_if_gnt, obs_ls_gnt, obs_if_rvalid, obs_ls_rvalid, obs_ls_err, obs_mem_req;
  logic [63:0] obs_mem_addr, obs_if_rdata, obs_ls_rdata, obs_starve;

  task automatic model_reset();
    m_owner  = 0;
    m_starve = 0;
    m_if_cnt = 0;
    m_ls_cnt = 0;
    mem_pend = 0;
  endtask

  // One clock cycle: drive memory, check all outputs mid-cycle, advance the model, return just after the edge.
  task automatic step();
    logic        e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_err, e_req, e_we;
    logic [63:0] e_addr, e_wdata, e_if_rd, e_ls_rd;
    int          nxt;
    if (mem_pend && mem_wait == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdata_fixed ? rdata_fix : {$urandom, $urandom};
      mem_pend   = 0;
    end else begin
      if (mem_pend) mem_wait--;
      mem_rvalid = !mem_pend && (stray_force || (stray_en && $urandom_range(0, 7) == 0));
      mem_rdata  = {$urandom, $urandom};
    end
    @(negedge clk);
    e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0; e_err = 0; e_req = 0; e_we = 0;
    e_addr = '0; e_wdata = '0; e_if_rd = '0; e_ls_rd = '0;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (if_req && (!ls_req || m_starve == MAXS)) begin
        e_if_gnt = 1; e_req = 1;
        e_addr = if_addr - (if_addr % 8);
        nxt = 1;
      end else if (ls_req) begin
        e_ls_gnt = 1;
        if (ls_addr % 8 == 0) begin
          e_req = 1; e_we = ls_we; e_addr = ls_addr; e_wdata = ls_wdata;
          nxt = 2;
        end else begin
          nxt = 3;
        end
      end
    end else if (m_owner == 1) begin
      if (mem_rvalid) begin e_if_rv = 1; e_if_rd = mem_rdata; nxt = 0; end
    end else if (m_owner == 2) begin
      if (mem_rvalid) begin e_ls_rv = 1; e_ls_rd = mem_rdata; nxt = 0; end
    end else begin
      e_ls_rv = 1; e_err = 1; nxt = 0;
    end

    check_eq("ctrl", 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err, mem_req, mem_we}),
             64'({e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_err, e_req, e_we}));
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wdata", mem_wdata, e_wdata);
    check_eq("if_rdata", if_rdata, e_if_rd);
    check_eq("ls_rdata", ls_rdata, e_ls_rd);
    check_eq("starve_cnt", 64'(dut.starve_cnt), 64'(m_starve));
`ifdef TINKER_ARB_STATS_EN
    check_eq("if_gnt_cnt", 64'(if_gnt_cnt), 64'(m_if_cnt));
    check_eq("ls_gnt_cnt", 64'(ls_gnt_cnt), 64'(m_ls_cnt));
`endif

    obs_if_gnt = if_gnt; obs_ls_gnt = ls_gnt; obs_if_rvalid = if_rvalid; obs_ls_rvalid = ls_rvalid;
    obs_ls_err = ls_err; obs_mem_req = mem_req; obs_mem_addr = mem_addr;
    obs_if_rdata = if_rdata; obs_ls_rdata = ls_rdata; obs_starve = 64'(dut.starve_cnt);

    if (e_if_gnt) m_starve = 0;
    else if (if_req) m_starve = (m_starve < MAXS) ? m_starve + 1 : MAXS;
    if (e_if_gnt) begin m_if_cnt++; if_hold = 0; end
    if (e_ls_gnt) begin m_ls_cnt++; ls_hold = 0; end
    if (e_req) begin
      mem_pend = 1;
      mem_wait = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
    end
    m_owner = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive();
    if (!if_hold) begin
      if_req  = ($urandom_range(0, 2) != 0);
      if_addr = {$urandom, $urandom};
      if_hold = if_req;
    end
    if (!ls_hold) begin
      ls_req   = ($urandom_range(0, 2) != 0);
      ls_we    = 1'($urandom_range(0, 1));
      ls_addr  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) ls_addr[2:0] = 3'b000;
      ls_wdata = {$urandom, $urandom};
      ls_hold  = ls_req;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctrl"}, 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_err, mem_req, mem_we}), 64'd0);
    check_eq({tag, "_bus"}, mem_addr | mem_wdata | if_rdata | ls_rdata, 64'd0);
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 64'h1000; ls_req = 1'b1; ls_we = 1'b1;
    ls_addr = 64'h2000; ls_wdata = 64'h55; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
    #1;
    check_outputs_zero("reset");
    check_eq("reset_state", 64'(dut.state_q), 64'd0);
    check_eq("reset_starve", 64'(dut.starve_cnt), 64'd0);
    if_req = 0; ls_req = 0; ls_we = 0; mem_rvalid = 0; mem_rdata = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fetch alone: address rounded down, response two cycles after grant
    lat_fix = 1; rdata_fixed = 1; rdata_fix = 64'hDEAD_BEEF_0000_1111;
    if_req = 1; if_addr = 64'h2004;
    step();
    check_eq("fetch_gnt", 64'(obs_if_gnt), 64'd1);
    check_eq("fetch_addr", obs_mem_addr, 64'h2000);
    if_req = 0;
    step();
    check_eq("fetch_wait", 64'(obs_if_rvalid), 64'd0);
    step();
    check_eq("fetch_rvalid", 64'(obs_if_rvalid), 64'd1);
    check_eq("fetch_rdata", obs_if_rdata, 64'hDEAD_BEEF_0000_1111);
    step();
    check_eq("fetch_rvalid_pulse", 64'(obs_if_rvalid), 64'd0);
    rdata_fixed = 0;

    // Simultaneous requests: LSU first, fetch in the next IDLE
    lat_fix = 0;
    if_req = 1; if_addr = 64'h3000;
    ls_req = 1; ls_we = 0; ls_addr = 64'h100;
    step();
    check_eq("both_ls_first", 64'({obs_ls_gnt, obs_if_gnt}), 64'b10);
    ls_req = 0;
    step();
    check_eq("both_ls_done", 64'(obs_ls_rvalid), 64'd1);
    step();
    check_eq("both_if_next", 64'(obs_if_gnt), 64'd1);
    if_req = 0;
    step();
    step();

    // Starvation: LSU always requesting, fetch eventually forced through
    ls_req = 1; ls_we = 0; ls_addr = 64'h200;
    if_req = 1; if_addr = 64'h4000;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (obs_if_gnt) begin
        got = 1;
        check_eq("starve_at_gnt", obs_starve, 64'(MAXS));
      end
    end
    if (!got) check_eq("starve_timeout", 64'd0, 64'd1);
    if_req = 0;
    step();
    check_eq("starve_cleared", obs_starve, 64'd0);
    step();
    check_eq("starve_ls_resumes", 64'(obs_ls_gnt), 64'd1);
    ls_req = 0;
    step();
    step();

    // Misaligned store: grant without memory access, error reply next cycle, stray mem_rvalid ignored
    ls_req = 1; ls_we = 1; ls_addr = 64'h103; ls_wdata = 64'h1234_5678;
    step();
    check_eq("mis_gnt", 64'({obs_ls_gnt, obs_mem_req}), 64'b10);
    ls_req = 0; stray_force = 1;
    step();
    check_eq("mis_err", 64'({obs_ls_rvalid, obs_ls_err}), 64'b11);
    check_eq("mis_rdata", obs_ls_rdata, 64'd0);
    stray_force = 0;
    step();
    check_eq("mis_done", 64'(obs_ls_rvalid), 64'd0);

    // Reset during a load in flight, then a late memory response
    lat_fix = 50;
    ls_req = 1; ls_we = 0; ls_addr = 64'h180;
    step();
    check_eq("rst_mid_gnt", 64'(obs_ls_gnt), 64'd1);
    ls_req = 0;
    step();
    reset = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    check_eq("rst_mid_state", 64'(dut.state_q), 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    stray_force = 1;
    step();
    check_eq("rst_late_rvalid", 64'(obs_ls_rvalid), 64'd0);
    stray_force = 0;
    check_eq("rst_late_state", 64'(dut.state_q), 64'd0);
    lat_fix = 0;

`ifdef TINKER_ARB_STATS_EN
    // Grant counters after three fetches and two loads from reset
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = 64'(i * 8);
      step();
      if_req = 0;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      ls_req = 1; ls_we = 0; ls_addr = 64'h800 + 64'(i * 8);
      step();
      ls_req = 0;
      step();
    end
    check_eq("stats_if", 64'(if_gnt_cnt), 64'd3);
    check_eq("stats_ls", 64'(ls_gnt_cnt), 64'd2);
`endif

    // Randomized traffic with random latency and stray responses
    lat_fix = -1; stray_en = 1;
    if_hold = 0; ls_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end
    if_req = 0; ls_req = 0; stray_en = 0;
    for (int i = 0; i < 8; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
